// File: rtl/fir_axi_pkg.sv
// Shared constants, FSM state type and history-index helper for the FIR engine.
package fir_axi_pkg;

  localparam int TAPE_NUM = 11;

  localparam logic [11:0] AP_CTRL  = 12'h000;
  localparam logic [11:0] DATA_LEN = 12'h010;
  localparam logic [11:0] TAP_BASE = 12'h020;
  localparam logic [11:0] TAP_END  = TAP_BASE + 12'(4 * TAPE_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } fir_state_e;

  // Slot of sample x[n-k] in the circular history when x[n] sits at ptr.
  function automatic logic [3:0] hist_idx(input logic [3:0] ptr, input logic [3:0] k);
    logic [4:0] wrapped;
    wrapped = {1'b0, ptr} + 5'd11 - {1'b0, k};
    return (ptr >= k) ? (ptr - k) : wrapped[3:0];
  endfunction

  function automatic logic is_tap_addr(input logic [11:0] addr);
    return (addr >= TAP_BASE) && (addr < TAP_END);
  endfunction

endpackage

// File: rtl/bram11.sv
// 11-word synchronous-read SRAM with byte write enables (read-before-write).
module bram11 (
  input  logic        clk,
  input  logic [3:0]  we,
  input  logic        en,
  input  logic [31:0] di,
  output logic [31:0] dout,
  input  logic [11:0] a
);

  logic [31:0] mem [0:10];
  logic [3:0]  idx;
  logic        unused_addr;

  assign idx         = a[5:2];
  assign unused_addr = ^{a[11:6], a[1:0]};

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (idx < 4'd11) begin
        for (int b = 0; b < 4; b++) begin
          if (we[b]) mem[idx][8*b +: 8] <= di[8*b +: 8];
        end
        dout <= mem[idx];
      end else begin
        dout <= '0;
      end
    end
  end

endmodule

// File: rtl/fir_axil_regs.sv
// AXI4-Lite slave: ap_ctrl/data_length registers and tap SRAM arbitration.
module fir_axil_regs
  import fir_axi_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   awready,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   fsm_tap_en,
  input  logic [pADDR_WIDTH-1:0] fsm_tap_a,
  input  logic                   sample_accept,
  input  logic                   last_done,
  output logic                   start_pulse,
  output logic [pDATA_WIDTH-1:0] data_length
);

  logic                   awready_q, awready_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   tap_pend_q, tap_pend_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   idle_q, idle_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic                   aw_hs, ar_hs, wr_tap, rd_tap;

  // Handshake decode; configuration is only honoured while idle.
  always_comb begin
    aw_hs       = awvalid && wvalid && awready_q;
    ar_hs       = arvalid && arready_q;
    wr_tap      = aw_hs && idle_q && is_tap_addr(awaddr);
    rd_tap      = ar_hs && idle_q && is_tap_addr(araddr);
    start_pulse = aw_hs && (awaddr == AP_CTRL) && wdata[0] && idle_q;
  end

  // Next-state for handshakes, read data path and status bits.
  always_comb begin
    awready_d  = awvalid && wvalid && !awready_q;
    // Writes win: a pending write blocks arready so the tap SRAM never sees both.
    arready_d  = arvalid && !arready_q && !tap_pend_q && !rvalid_q && !(awvalid && wvalid);
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    tap_pend_d = tap_pend_q;
    start_d    = start_q;
    done_d     = done_q;
    idle_d     = idle_q;
    len_d      = len_q;

    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (tap_pend_q) begin
      rvalid_d   = 1'b1;
      rdata_d    = tap_Do;
      tap_pend_d = 1'b0;
    end else if (rd_tap) begin
      tap_pend_d = 1'b1;
    end else if (ar_hs) begin
      rvalid_d = 1'b1;
      if (araddr == AP_CTRL)       rdata_d = {{(pDATA_WIDTH-3){1'b0}}, idle_q, done_q, start_q};
      else if (araddr == DATA_LEN) rdata_d = len_q;
      else                         rdata_d = '0;
    end

    if (ar_hs && (araddr == AP_CTRL)) done_d = 1'b0;
    if (sample_accept) start_d = 1'b0;
    if (start_pulse) begin
      start_d = 1'b1;
      done_d  = 1'b0;
      idle_d  = 1'b0;
    end
    if (last_done) begin
      done_d = 1'b1;
      idle_d = 1'b1;
    end
    if (aw_hs && idle_q && (awaddr == DATA_LEN)) len_d = wdata;
  end

  // Tap SRAM belongs to the bus while idle and to the MAC engine otherwise.
  always_comb begin
    if (idle_q) begin
      tap_EN = wr_tap || rd_tap;
      tap_WE = wr_tap ? 4'hF : 4'h0;
      tap_A  = wr_tap ? (awaddr - TAP_BASE) : (araddr - TAP_BASE);
      tap_Di = wdata;
    end else begin
      tap_EN = fsm_tap_en;
      tap_WE = 4'h0;
      tap_A  = fsm_tap_a;
      tap_Di = '0;
    end
  end

  // Register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q  <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      tap_pend_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
      len_q      <= '0;
    end else begin
      awready_q  <= awready_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      tap_pend_q <= tap_pend_d;
      start_q    <= start_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
      len_q      <= len_d;
    end
  end

  assign awready     = awready_q;
  assign wready      = awready_q;
  assign arready     = arready_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign data_length = len_q;

endmodule

// File: rtl/fir_axi.sv
// 11-tap FIR engine: history clear, per-sample MAC sequencing and stream output.
module fir_axi
  import fir_axi_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAPE_NUM
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam logic [3:0] LAST_TAP = 4'(Tape_Num - 1);

  fir_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             ptr_q, ptr_d;
  logic [pDATA_WIDTH-1:0] x_q, x_d;
  logic [pDATA_WIDTH-1:0] acc_q, acc_d;
  logic [pDATA_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                   sm_tvalid_q, sm_tvalid_d;
  logic                   sm_tlast_q, sm_tlast_d;
  logic [pDATA_WIDTH-1:0] sm_tdata_q, sm_tdata_d;
  logic [pDATA_WIDTH-1:0] mac_x, mac_sum;
  logic                   fsm_tap_en;
  logic [pADDR_WIDTH-1:0] fsm_tap_a;
  logic                   sample_accept, last_done, start_pulse;
  logic [pDATA_WIDTH-1:0] data_length;
  logic                   unused_tlast;

  assign unused_tlast = ss_tlast;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [3:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  fir_axil_regs #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_regs (
    .clk          (axis_clk),
    .rst_n        (axis_rst_n),
    .awvalid      (awvalid),
    .awaddr       (awaddr),
    .wvalid       (wvalid),
    .wdata        (wdata),
    .awready      (awready),
    .wready       (wready),
    .arvalid      (arvalid),
    .araddr       (araddr),
    .arready      (arready),
    .rvalid       (rvalid),
    .rready       (rready),
    .rdata        (rdata),
    .tap_WE       (tap_WE),
    .tap_EN       (tap_EN),
    .tap_Di       (tap_Di),
    .tap_A        (tap_A),
    .tap_Do       (tap_Do),
    .fsm_tap_en   (fsm_tap_en),
    .fsm_tap_a    (fsm_tap_a),
    .sample_accept(sample_accept),
    .last_done    (last_done),
    .start_pulse  (start_pulse),
    .data_length  (data_length)
  );

  assign ss_tready = (state_q == S_WAIT_IN) && ss_tvalid;

  // FSM next state; MAC step k uses tap k and x[n-k] read one cycle earlier
  // (x[n] itself comes from x_q since the history slot is written that same cycle).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    x_d           = x_q;
    acc_d         = acc_q;
    out_cnt_d     = out_cnt_q;
    sm_tvalid_d   = sm_tvalid_q;
    sm_tlast_d    = sm_tlast_q;
    sm_tdata_d    = sm_tdata_q;
    sample_accept = 1'b0;
    last_done     = 1'b0;
    mac_x         = (cnt_q == 4'd0) ? x_q : data_Do;
    // Low 32 bits of the product are identical for signed and unsigned operands.
    mac_sum       = ((cnt_q == 4'd0) ? '0 : acc_q) + mac_x * tap_Do;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pulse) begin
          state_d   = S_CLEAR;
          cnt_d     = 4'd0;
          ptr_d     = 4'd0;
          out_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_TAP) begin
          state_d = S_WAIT_IN;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT_IN: begin
        if (ss_tvalid) begin
          sample_accept = 1'b1;
          x_d           = ss_tdata;
          cnt_d         = 4'd0;
          state_d       = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = mac_sum;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_TAP) begin
          state_d     = S_OUT;
          cnt_d       = 4'd0;
          sm_tvalid_d = 1'b1;
          sm_tdata_d  = mac_sum;
          sm_tlast_d  = (out_cnt_q + 1'b1) == data_length;
          ptr_d       = (ptr_q == LAST_TAP) ? 4'd0 : ptr_q + 4'd1;
        end
      end
      S_OUT: begin
        if (sm_tready) begin
          sm_tvalid_d = 1'b0;
          sm_tlast_d  = 1'b0;
          out_cnt_d   = out_cnt_q + 1'b1;
          if (sm_tlast_q) begin
            state_d   = S_DONE;
            last_done = 1'b1;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SRAM requests: history clear, new-sample write, and operand reads for the next MAC step.
  always_comb begin
    data_EN    = 1'b0;
    data_WE    = 4'h0;
    data_A     = '0;
    data_Di    = '0;
    fsm_tap_en = 1'b0;
    fsm_tap_a  = '0;
    unique case (state_q)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(cnt_q);
      end
      S_WAIT_IN: begin
        if (ss_tvalid) begin
          data_EN    = 1'b1;
          data_WE    = 4'hF;
          data_A     = word_addr(ptr_q);
          data_Di    = ss_tdata;
          fsm_tap_en = 1'b1;
          fsm_tap_a  = word_addr(4'd0);
        end
      end
      S_MAC: begin
        if (cnt_q != LAST_TAP) begin
          data_EN    = 1'b1;
          data_A     = word_addr(hist_idx(ptr_q, cnt_q + 4'd1));
          fsm_tap_en = 1'b1;
          fsm_tap_a  = word_addr(cnt_q + 4'd1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and FSM state.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ptr_q       <= 4'd0;
      x_q         <= '0;
      acc_q       <= '0;
      out_cnt_q   <= '0;
      sm_tvalid_q <= 1'b0;
      sm_tlast_q  <= 1'b0;
      sm_tdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      out_cnt_q   <= out_cnt_d;
      sm_tvalid_q <= sm_tvalid_d;
      sm_tlast_q  <= sm_tlast_d;
      sm_tdata_q  <= sm_tdata_d;
    end
  end

  assign sm_tvalid = sm_tvalid_q;
  assign sm_tlast  = sm_tlast_q;
  assign sm_tdata  = sm_tdata_q;

endmodule

// File: tb/tb_fir_axi.sv
// Randomized self-checking bench for fir_axi against a direct-convolution model.
module tb_fir_axi;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        awvalid, awready, wvalid, wready;
  logic [11:0] awaddr;
  logic [31:0] wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] araddr;
  logic [31:0] rdata;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tready, sm_tvalid, sm_tlast;
  logic [31:0] sm_tdata;
  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [31:0] tap_Di, tap_Do, data_Di, data_Do;
  logic [11:0] tap_A, data_A;

  always #5 axis_clk = ~axis_clk;

  fir_axi dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
    .awaddr(awaddr), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tdata(sm_tdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  bram11 u_tap_ram  (.clk(axis_clk), .we(tap_WE),  .en(tap_EN),  .di(tap_Di),  .dout(tap_Do),  .a(tap_A));
  bram11 u_data_ram (.clk(axis_clk), .we(data_WE), .en(data_EN), .di(data_Di), .dout(data_Do), .a(data_A));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tap_cur [11];
  logic [31:0] in_buf [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  // y[n] = sum_k h[k] * x[n-k], x[<0] = 0, all mod 2^32.
  function automatic logic [31:0] ref_y(input int n);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < 11; k++) begin
      if (n - k >= 0) acc = acc + tap_cur[k] * in_buf[n - k];
    end
    return acc;
  endfunction

  task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
    int cyc;
    @(posedge axis_clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
    cyc = 0;
    do begin
      @(negedge axis_clk);
      cyc++;
    end while (!(awready && wready) && cyc < 20);
    if (!(awready && wready)) check_val("awready_timeout", 32'(awready), 32'd1);
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    $display("axil write addr=0x%03h data=0x%08h", addr, data);
  endtask

  task automatic axil_read(input logic [11:0] addr, output logic [31:0] data);
    int cyc;
    data = 32'hDEAD_BEEF;
    @(posedge axis_clk); #1;
    arvalid = 1'b1; araddr = addr;
    cyc = 0;
    do begin
      @(negedge axis_clk);
      cyc++;
    end while (!arready && cyc < 20);
    if (!arready) check_val("arready_timeout", 32'(arready), 32'd1);
    @(posedge axis_clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    cyc = 0;
    do begin
      @(negedge axis_clk);
      cyc++;
    end while (!rvalid && cyc < 20);
    if (!rvalid) check_val("rvalid_timeout", 32'(rvalid), 32'd1);
    else data = rdata;
    @(posedge axis_clk); #1;
    rready = 1'b0;
    $display("axil read  addr=0x%03h data=0x%08h", addr, data);
  endtask

  // Streams in_buf[0..n-1] through the DUT with random bubbles and back-pressure.
  task automatic run_stream(input int n, input bit status_probe, input int stall_at);
    int budget;
    budget = n * 60 + 200;
    fork
      begin : producer
        int idx, cyc;
        bit accepted;
        idx = 0; cyc = 0; accepted = 1'b0;
        while (idx < n && cyc < budget) begin
          @(posedge axis_clk); #1;
          if (accepted) ss_tvalid = 1'b0;
          accepted = 1'b0;
          if (!ss_tvalid && $urandom_range(0, 3) != 0) begin
            ss_tvalid = 1'b1;
            ss_tdata  = in_buf[idx];
            ss_tlast  = (idx == n - 1);
          end
          @(negedge axis_clk);
          cyc++;
          if (ss_tvalid && ss_tready) begin
            idx++;
            accepted = 1'b1;
          end
        end
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
        if (idx < n) check_val("in_timeout", 32'(idx), 32'(n));
      end
      begin : consumer
        int got, cyc;
        bit stalled;
        logic [31:0] hold;
        got = 0; cyc = 0; stalled = 1'b0;
        while (got < n && cyc < budget) begin
          @(posedge axis_clk); #1;
          if (stall_at >= 0 && got == stall_at && sm_tvalid && !stalled) begin
            stalled   = 1'b1;
            sm_tready = 1'b0;
            hold      = sm_tdata;
            for (int s = 0; s < 20; s++) begin
              @(negedge axis_clk);
              check_val("stall_valid", 32'(sm_tvalid), 32'd1);
              check_val("stall_data", sm_tdata, hold);
              check_val("stall_no_accept", 32'(ss_tready), 32'd0);
              @(posedge axis_clk); #1;
            end
            cyc += 20;
          end
          sm_tready = ($urandom_range(0, 3) != 0);
          @(negedge axis_clk);
          cyc++;
          if (sm_tvalid && sm_tready) begin
            $display("out %0d data=%0d last=%0b", got, $signed(sm_tdata), sm_tlast);
            check_val("out_data", sm_tdata, ref_y(got));
            check_val("out_last", 32'(sm_tlast), 32'(got == n - 1));
            got++;
          end
        end
        @(posedge axis_clk); #1;
        sm_tready = 1'b0;
        if (got < n) check_val("out_timeout", 32'(got), 32'(n));
      end
      begin : status_reader
        logic [31:0] st;
        if (status_probe) begin
          repeat (40) @(posedge axis_clk);
          axil_read(12'h000, st);
          check_val("busy_idle_bit", 32'(st[2]), 32'd0);
        end
      end
    join
  endtask

  logic [31:0] rd;
  int spec_taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    axis_rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = '0; sm_tready = 1'b0;
    for (int k = 0; k < 11; k++) tap_cur[k] = 32'(spec_taps[k]);

    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    check_val("rst_ss_tready", 32'(ss_tready), 32'd0);
    check_val("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check_val("rst_sm_tlast", 32'(sm_tlast), 32'd0);
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_sram_en", {30'd0, tap_EN, data_EN}, 32'd0);
    check_val("rst_sram_we", {24'd0, tap_WE, data_WE}, 32'd0);
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;

    axil_read(12'h000, rd);
    check_val("rst_ap_ctrl", rd, 32'h4);
    axil_read(12'h010, rd);
    check_val("rst_data_len", rd, 32'd0);

    // Configuration and readback.
    axil_write(12'h010, 32'd600);
    for (int k = 0; k < 11; k++) axil_write(12'(12'h020 + 4 * k), tap_cur[k]);
    for (int k = 0; k < 11; k++) begin
      axil_read(12'(12'h020 + 4 * k), rd);
      check_val($sformatf("tap_rb_%0d", k), rd, tap_cur[k]);
    end
    axil_read(12'h010, rd);
    check_val("len_rb", rd, 32'd600);

    // Impulse response with a mid-run status probe.
    axil_write(12'h010, 32'd12);
    in_buf.delete();
    for (int i = 0; i < 12; i++) in_buf.push_back((i == 0) ? 32'd1 : 32'd0);
    axil_write(12'h000, 32'd1);
    run_stream(12, 1'b1, -1);
    axil_read(12'h000, rd);
    check_val("done_after_impulse", rd, 32'h6);
    axil_read(12'h000, rd);
    check_val("done_cleared_on_read", rd, 32'h4);

    // Step response; ap_start visible before the first sample.
    axil_write(12'h010, 32'd11);
    in_buf.delete();
    for (int i = 0; i < 11; i++) in_buf.push_back(32'd1);
    axil_write(12'h000, 32'd1);
    axil_read(12'h000, rd);
    check_val("start_pending", rd, 32'h1);
    run_stream(11, 1'b0, -1);
    axil_read(12'h000, rd);
    check_val("done_after_step", rd, 32'h6);

    // Long random run with a 20-cycle output stall.
    axil_write(12'h010, 32'd600);
    in_buf.delete();
    for (int i = 0; i < 600; i++) in_buf.push_back($urandom);
    axil_write(12'h000, 32'd1);
    run_stream(600, 1'b0, 300);
    axil_read(12'h000, rd);
    check_val("done_after_long", rd, 32'h6);

    // Reset in the middle of a run returns straight to idle.
    axil_write(12'h010, 32'd5);
    axil_write(12'h000, 32'd1);
    @(posedge axis_clk); #1;
    ss_tvalid = 1'b1; ss_tdata = 32'd7; sm_tready = 1'b0;
    repeat (30) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b0;
    @(negedge axis_clk);
    check_val("midrst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check_val("midrst_ss_tready", 32'(ss_tready), 32'd0);
    @(posedge axis_clk); #1;
    ss_tvalid = 1'b0;
    axis_rst_n = 1'b1;
    axil_read(12'h000, rd);
    check_val("midrst_ap_ctrl", rd, 32'h4);
    axil_read(12'h010, rd);
    check_val("midrst_data_len", rd, 32'd0);

    // Taps survive reset.
    axil_write(12'h010, 32'd3);
    in_buf.delete();
    in_buf.push_back(32'd1); in_buf.push_back(32'd0); in_buf.push_back(32'd0);
    axil_write(12'h000, 32'd1);
    run_stream(3, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
